// File: rtl/detect_udiv_29u22u_8_seq.sv
// Sequential restoring unsigned divider (29u / 22u -> 8u quotient, 22u remainder), one quotient bit per cycle.
// Divide-by-zero and quotient overflow are classified at accept and reported one cycle later with a saturated quotient.
module detect_udiv_29u22u_8_seq #(
  parameter int DIVIDEND_W = 29,
  parameter int DIVISOR_W  = 22,
  parameter int QUO_W      = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [QUO_W-1:0]      quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  ovf,
  output logic                  dbz
);

  localparam int HI_W  = DIVIDEND_W - QUO_W;
  localparam int CNT_W = (QUO_W > 1) ? $clog2(QUO_W) : 1;
  localparam int CMP_W = HI_W + DIVISOR_W;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_next;
  logic [DIVISOR_W-1:0] rem_q;
  logic [DIVISOR_W-1:0] dsr_q;
  logic [QUO_W-1:0]     low_q;
  logic [QUO_W-1:0]     quo_acc;
  logic [CNT_W-1:0]     cnt;
  logic                 spec_dbz;
  logic                 spec_ovf;

  logic                 accept;
  logic                 finish;
  logic                 special;
  logic [HI_W-1:0]      hi;
  logic                 ovf_in;
  logic [DIVISOR_W:0]   trial;
  logic [DIVISOR_W:0]   diff;
  logic                 ge;
  logic [DIVISOR_W-1:0] rem_next;
  logic [QUO_W-1:0]     quo_next;

  assign din_ready  = (state == IDLE) & ~ap_rst;
  assign dout_valid = (state == DONE);
  assign accept     = din_valid & din_ready;
  assign special    = spec_dbz | spec_ovf;

  // The quotient fits in QUO_W bits only if the upper dividend bits are below the divisor.
  assign hi     = dividend[DIVIDEND_W-1:QUO_W];
  assign ovf_in = ({{DIVISOR_W{1'b0}}, hi} >= {{HI_W{1'b0}}, divisor});

  assign trial    = {rem_q, low_q[QUO_W-1]};
  assign diff     = trial - {1'b0, dsr_q};
  assign ge       = (trial >= {1'b0, dsr_q});
  assign rem_next = DIVISOR_W'(ge ? diff : trial);
  assign quo_next = {quo_acc[QUO_W-2:0], ge};

  assign finish = (state == CALC) & (special | (cnt == CNT_W'(QUO_W - 1)));

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (finish) state_next = DONE;
      DONE:    if (dout_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rem_q     <= '0;
      dsr_q     <= '0;
      low_q     <= '0;
      quo_acc   <= '0;
      cnt       <= '0;
      spec_dbz  <= 1'b0;
      spec_ovf  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      if (accept) begin
        dsr_q    <= divisor;
        rem_q    <= DIVISOR_W'(hi);
        low_q    <= dividend[QUO_W-1:0];
        quo_acc  <= '0;
        cnt      <= '0;
        spec_dbz <= (divisor == '0);
        spec_ovf <= (divisor != '0) & ovf_in;
      end else if (state == CALC) begin
        rem_q   <= rem_next;
        low_q   <= {low_q[QUO_W-2:0], 1'b0};
        quo_acc <= quo_next;
        cnt     <= cnt + 1'b1;
      end
      // Result registers only change when entering DONE, so they hold through DONE and IDLE.
      if (finish) begin
        quotient  <= special ? '1 : quo_next;
        remainder <= special ? '0 : rem_next;
        ovf       <= spec_ovf;
        dbz       <= spec_dbz;
      end
    end
  end

endmodule

// File: tb/tb_detect_udiv_29u22u_8_seq.sv
// Directed and random checks of detect_udiv_29u22u_8_seq against an arithmetic division model.
module tb_detect_udiv_29u22u_8_seq;

  localparam int QUO = 8;

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [28:0] dividend = '0;
  logic [21:0] divisor = '0;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic [7:0]  quotient;
  logic [21:0] remainder;
  logic        ovf;
  logic        dbz;

  int tests = 0;
  int fails = 0;

  detect_udiv_29u22u_8_seq dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .din_valid(din_valid), .din_ready(din_ready),
    .dividend(dividend), .divisor(divisor),
    .dout_valid(dout_valid), .dout_ready(dout_ready),
    .quotient(quotient), .remainder(remainder),
    .ovf(ovf), .dbz(dbz)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model(input logic [28:0] a, input logic [21:0] d,
                       output logic [63:0] eq, output logic [63:0] er,
                       output logic eo, output logic ez);
    logic [63:0] a64, d64;
    a64 = {35'd0, a};
    d64 = {42'd0, d};
    eo = 1'b0; ez = 1'b0;
    if (d64 == 0) begin
      ez = 1'b1; eq = 255; er = 0;
    end else if (a64 / d64 > 255) begin
      eo = 1'b1; eq = 255; er = 0;
    end else begin
      eq = a64 / d64; er = a64 % d64;
    end
  endtask

  task automatic do_op(input logic [28:0] a, input logic [21:0] d, input bit early);
    logic [63:0] eq, er;
    logic eo, ez;
    int lat, w;
    model(a, d, eq, er, eo, ez);
    w = 0;
    while (!din_ready && w < 50) begin @(negedge ap_clk); w++; end
    check("din_ready_before", {63'd0, din_ready}, 1);
    dividend = a; divisor = d; din_valid = 1'b1; dout_ready = early;
    @(negedge ap_clk);
    din_valid = 1'b0;
    lat = 0;
    while (!dout_valid && lat < 50) begin @(negedge ap_clk); lat++; end
    check("latency", 64'(lat), (eo || ez) ? 64'd1 : 64'(QUO));
    check("quotient", {56'd0, quotient}, eq);
    check("remainder", {42'd0, remainder}, er);
    check("ovf", {63'd0, ovf}, {63'd0, eo});
    check("dbz", {63'd0, dbz}, {63'd0, ez});
    if (!eo && !ez) begin
      check("invariant", {56'd0, quotient} * {42'd0, d} + {42'd0, remainder}, {35'd0, a});
      check("rem_lt_div", {63'd0, remainder < d}, 1);
    end
    dout_ready = 1'b1;
    if (!early) @(negedge ap_clk);
    else @(negedge ap_clk);
    dout_ready = 1'b0;
    check("dout_valid_drop", {63'd0, dout_valid}, 0);
    check("din_ready_after", {63'd0, din_ready}, 1);
  endtask

  initial begin
    logic [28:0] ra;
    logic [21:0] rd;
    int w;

    // Reset state
    #2;
    check("rst_din_ready", {63'd0, din_ready}, 0);
    check("rst_dout_valid", {63'd0, dout_valid}, 0);
    check("rst_quotient", {56'd0, quotient}, 0);
    check("rst_remainder", {42'd0, remainder}, 0);
    check("rst_flags", {62'd0, ovf, dbz}, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("din_ready_post_rst", {63'd0, din_ready}, 1);

    // Directed cases
    do_op(29'd1000, 22'd7, 1'b0);
    do_op(29'd536870911, 22'd4194303, 1'b0);
    do_op(29'd2048, 22'd8, 1'b0);
    do_op(29'd2047, 22'd8, 1'b1);
    do_op(29'd12345, 22'd0, 1'b0);
    do_op(29'd500, 22'd3, 1'b1);

    // Backpressure and blocked input: 1000/7 with stray din_valid pulses
    dividend = 29'd1000; divisor = 22'd7; din_valid = 1'b1; dout_ready = 1'b0;
    @(negedge ap_clk);
    din_valid = 1'b0;
    w = 0;
    while (!dout_valid && w < 50) begin
      check("bp_calc_din_ready", {63'd0, din_ready}, 0);
      dividend = 29'd99999; divisor = 22'd1; din_valid = w[0];
      @(negedge ap_clk);
      w++;
    end
    din_valid = 1'b0;
    check("bp_latency", 64'(w), 64'(QUO));
    for (int i = 0; i < 5; i++) begin
      dividend = 29'd77; divisor = 22'd0; din_valid = 1'b1;
      check("bp_dout_valid", {63'd0, dout_valid}, 1);
      check("bp_din_ready", {63'd0, din_ready}, 0);
      check("bp_quotient", {56'd0, quotient}, 142);
      check("bp_remainder", {42'd0, remainder}, 6);
      check("bp_flags", {62'd0, ovf, dbz}, 0);
      @(negedge ap_clk);
      din_valid = 1'b0;
    end
    dout_ready = 1'b1;
    @(negedge ap_clk);
    dout_ready = 1'b0;
    check("bp_release_din_ready", {63'd0, din_ready}, 1);
    check("bp_release_dout_valid", {63'd0, dout_valid}, 0);
    check("bp_hold_quotient", {56'd0, quotient}, 142);

    // Reset during the 4th CALC cycle of 1000/7
    dividend = 29'd1000; divisor = 22'd7; din_valid = 1'b1;
    @(negedge ap_clk);
    din_valid = 1'b0;
    repeat (3) @(negedge ap_clk);
    ap_rst = 1'b1;
    #1;
    check("mid_rst_din_ready", {63'd0, din_ready}, 0);
    check("mid_rst_dout_valid", {63'd0, dout_valid}, 0);
    check("mid_rst_quotient", {56'd0, quotient}, 0);
    check("mid_rst_remainder", {42'd0, remainder}, 0);
    check("mid_rst_flags", {62'd0, ovf, dbz}, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("mid_rst_recover_ready", {63'd0, din_ready}, 1);
    do_op(29'd500, 22'd3, 1'b0);

    // Random sweep, mixing wide and narrow divisors to hit both normal and overflow paths
    for (int i = 0; i < 600; i++) begin
      ra = 29'($urandom);
      rd = 22'($urandom >> $urandom_range(0, 31));
      if ($urandom_range(0, 40) == 0) rd = '0;
      do_op(ra, rd, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
